// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller: forwarding selects,
// MD sequencer states and register-field width.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_GPR = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // MEM is the younger producer, so it takes priority over WB; $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic             mem_rw,
    input logic [REG_W-1:0] mem_we,
    input logic             wb_rw,
    input logic [REG_W-1:0] wb_we,
    input logic [REG_W-1:0] src
  );
    if (mem_rw && mem_we != '0 && mem_we == src) return FWD_MEM;
    if (wb_rw && wb_we != '0 && wb_we == src)    return FWD_WB;
    return FWD_GPR;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage register fields in, forwarding,
// stall/flush, MD sequencing and performance counters out.
interface hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] ID_Rs, ID_Rt;
  logic             ID_UseRs, ID_UseRt;
  logic             ID_IsMd, ID_MdIsDiv, ID_ReadsHiLo, ID_Jump;
  logic [REG_W-1:0] EX_Rs, EX_Rt, EX_WeSel;
  logic             EX_MemR, EX_BranchTaken;
  logic [REG_W-1:0] MEM_WeSel;
  logic             MEM_RegW;
  logic [REG_W-1:0] WB_WeSel;
  logic             WB_RegW;

  logic [1:0]       FwdA, FwdB;
  logic             PcStall, IfIdStall, IfIdFlush, IdExFlush;
  logic             MdStart, MdBusy;
  logic [CNT_W-1:0] StallCycles, FlushCycles;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_IsMd, ID_MdIsDiv, ID_ReadsHiLo, ID_Jump,
    output EX_Rs, EX_Rt, EX_WeSel, EX_MemR, EX_BranchTaken,
    output MEM_WeSel, MEM_RegW, WB_WeSel, WB_RegW,
    input  FwdA, FwdB, PcStall, IfIdStall, IfIdFlush, IdExFlush,
    input  MdStart, MdBusy, StallCycles, FlushCycles
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_IsMd, ID_MdIsDiv, ID_ReadsHiLo, ID_Jump,
    input  EX_Rs, EX_Rt, EX_WeSel, EX_MemR, EX_BranchTaken,
    input  MEM_WeSel, MEM_RegW, WB_WeSel, WB_RegW,
    output FwdA, FwdB, PcStall, IfIdStall, IfIdFlush, IdExFlush,
    output MdStart, MdBusy, StallCycles, FlushCycles
  );
endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// MULT/DIV sequencer: issues the start pulse, tracks occupancy with a down
// counter and flags HI/LO hazards for the ID instruction.
module md_seq
  import pipe_pkg::*;
#(
  parameter int MD_MUL_CYCLES = 5,
  parameter int MD_DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic is_md_i,
  input  logic md_is_div_i,
  input  logic reads_hilo_i,
  input  logic lu_i,
  input  logic br_taken_i,
  output logic md_start_o,
  output logic md_busy_o,
  output logic md_hz_o
);

  localparam int CW = (MD_DIV_CYCLES > 1) ? $clog2(MD_DIV_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MD_MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(MD_DIV_CYCLES - 1);

  md_state_e      state_q;
  logic [CW-1:0]  cnt_q;
  logic           issue;

  // An MD op held back by a load-use stall or squashed by a branch must not start.
  assign issue      = (state_q == MD_IDLE) && is_md_i && !lu_i && !br_taken_i;
  assign md_start_o = issue && !rst;
  assign md_busy_o  = (state_q == MD_BUSY) && !rst;
  assign md_hz_o    = md_busy_o && (is_md_i || reads_hilo_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (issue) begin
            cnt_q   <= md_is_div_i ? DIV_LD : MUL_LD;
            state_q <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - CW'(1);
          else             state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: EX forwarding, load-use
// stall, branch/jump flushes, MD sequencing and stall/flush cycle counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_MUL_CYCLES = 5,
  parameter int MD_DIV_CYCLES = 10,
  parameter int CNT_W         = 32
) (
  input logic         Clk,
  input logic         Reset,
  hazard_ctrl_if.slave hz
);

  logic             lu, md_hz, md_start, md_busy;
  logic             stall, ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign lu = hz.EX_MemR && (hz.EX_WeSel != '0) &&
              ((hz.ID_UseRs && hz.ID_Rs == hz.EX_WeSel) ||
               (hz.ID_UseRt && hz.ID_Rt == hz.EX_WeSel));

  md_seq #(
    .MD_MUL_CYCLES (MD_MUL_CYCLES),
    .MD_DIV_CYCLES (MD_DIV_CYCLES)
  ) u_md_seq (
    .clk          (Clk),
    .rst          (Reset),
    .is_md_i      (hz.ID_IsMd),
    .md_is_div_i  (hz.ID_MdIsDiv),
    .reads_hilo_i (hz.ID_ReadsHiLo),
    .lu_i         (lu),
    .br_taken_i   (hz.EX_BranchTaken),
    .md_start_o   (md_start),
    .md_busy_o    (md_busy),
    .md_hz_o      (md_hz)
  );

  // A taken branch squashes the ID instruction, so any stall it caused is moot.
  assign stall      = !Reset && (lu || md_hz) && !hz.EX_BranchTaken;
  assign ifid_flush = !Reset && (hz.EX_BranchTaken || (hz.ID_Jump && !stall));
  assign idex_flush = !Reset && (stall || hz.EX_BranchTaken);

  assign hz.FwdA = Reset ? FWD_GPR :
                   fwd_sel(hz.MEM_RegW, hz.MEM_WeSel, hz.WB_RegW, hz.WB_WeSel, hz.EX_Rs);
  assign hz.FwdB = Reset ? FWD_GPR :
                   fwd_sel(hz.MEM_RegW, hz.MEM_WeSel, hz.WB_RegW, hz.WB_WeSel, hz.EX_Rt);

  assign hz.PcStall   = stall;
  assign hz.IfIdStall = stall;
  assign hz.IfIdFlush = ifid_flush;
  assign hz.IdExFlush = idex_flush;
  assign hz.MdStart   = md_start;
  assign hz.MdBusy    = md_busy;

  assign stall_cnt_d = stall      ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = ifid_flush ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCycles = Reset ? '0 : stall_cnt_q;
  assign hz.FlushCycles = Reset ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for the combinational paths
// plus MD/reset sequences, expectations queued per cycle and checked mid-cycle.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt, is_md, md_div, hilo, jump;
    logic [4:0] ex_rs, ex_rt, ex_we;
    logic       ex_memr, br;
    logic [4:0] mem_we;
    logic       mem_rw;
    logic [4:0] wb_we;
    logic       wb_rw;
  } in_t;

  typedef struct packed {
    logic [1:0] fwda, fwdb;
    logic       stall, ififl, idfl, start, busy;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  typedef struct packed {
    exp_t        e;
    logic [31:0] sc, fc;
  } sb_t;

  logic Clk, Reset;
  int   checks, errors;
  int   tot_s, tot_f;
  sb_t  sb_q[$];
  vec_t tbl[$];

  hazard_ctrl_if #(.CNT_W(32)) hz ();

  hazard_ctrl #(.MD_MUL_CYCLES(5), .MD_DIV_CYCLES(10), .CNT_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t i);
    Reset             = i.rst;
    hz.ID_Rs          = i.id_rs;
    hz.ID_Rt          = i.id_rt;
    hz.ID_UseRs       = i.use_rs;
    hz.ID_UseRt       = i.use_rt;
    hz.ID_IsMd        = i.is_md;
    hz.ID_MdIsDiv     = i.md_div;
    hz.ID_ReadsHiLo   = i.hilo;
    hz.ID_Jump        = i.jump;
    hz.EX_Rs          = i.ex_rs;
    hz.EX_Rt          = i.ex_rt;
    hz.EX_WeSel       = i.ex_we;
    hz.EX_MemR        = i.ex_memr;
    hz.EX_BranchTaken = i.br;
    hz.MEM_WeSel      = i.mem_we;
    hz.MEM_RegW       = i.mem_rw;
    hz.WB_WeSel       = i.wb_we;
    hz.WB_RegW        = i.wb_rw;
  endtask

  // One clock cycle: drive after the edge, queue the expectation, check at negedge.
  task automatic cyc(input in_t i, input exp_t e, input string tag);
    sb_t s, got;
    @(posedge Clk);
    #1;
    apply(i);
    s.e  = e;
    s.sc = i.rst ? 32'd0 : 32'(tot_s);
    s.fc = i.rst ? 32'd0 : 32'(tot_f);
    sb_q.push_back(s);
    if (i.rst) begin
      tot_s = 0;
      tot_f = 0;
    end else begin
      tot_s += int'(e.stall);
      tot_f += int'(e.ififl);
    end
    @(negedge Clk);
    got = sb_q.pop_front();
    chk({tag, ".FwdA"},        32'(hz.FwdA),      32'(got.e.fwda));
    chk({tag, ".FwdB"},        32'(hz.FwdB),      32'(got.e.fwdb));
    chk({tag, ".PcStall"},     32'(hz.PcStall),   32'(got.e.stall));
    chk({tag, ".IfIdStall"},   32'(hz.IfIdStall), 32'(got.e.stall));
    chk({tag, ".IfIdFlush"},   32'(hz.IfIdFlush), 32'(got.e.ififl));
    chk({tag, ".IdExFlush"},   32'(hz.IdExFlush), 32'(got.e.idfl));
    chk({tag, ".MdStart"},     32'(hz.MdStart),   32'(got.e.start));
    chk({tag, ".MdBusy"},      32'(hz.MdBusy),    32'(got.e.busy));
    chk({tag, ".StallCycles"}, hz.StallCycles,    got.sc);
    chk({tag, ".FlushCycles"}, hz.FlushCycles,    got.fc);
  endtask

  initial begin
    vec_t v;
    in_t  i;
    exp_t e;
    checks = 0; errors = 0; tot_s = 0; tot_f = 0;
    apply('0);
    Reset = 1'b1;

    // ---- vector table ----
    v = '0; v.i.mem_rw = 1; v.i.mem_we = 8; v.i.wb_rw = 1; v.i.wb_we = 8;
    v.i.ex_rs = 8; v.i.ex_rt = 9; v.e.fwda = 2'b10; tbl.push_back(v);
    v.i.wb_we = 9; v.e.fwdb = 2'b01; tbl.push_back(v);
    v = '0; v.i.mem_rw = 1; v.i.wb_rw = 1; tbl.push_back(v);
    v = '0; v.i.wb_rw = 1; v.i.wb_we = 3; v.i.ex_rs = 3; v.e.fwda = 2'b01; tbl.push_back(v);
    v = '0; v.i.mem_we = 7; v.i.ex_rt = 7; tbl.push_back(v);
    v = '0; v.i.ex_memr = 1; v.i.ex_we = 5; v.i.use_rt = 1; v.i.id_rt = 5;
    v.e.stall = 1; v.e.idfl = 1; tbl.push_back(v);
    v.i.use_rt = 0; v.e = '0; tbl.push_back(v);
    v = '0; v.i.ex_memr = 1; v.i.use_rt = 1; tbl.push_back(v);
    v = '0; v.i.ex_memr = 1; v.i.ex_we = 12; v.i.use_rs = 1; v.i.id_rs = 12;
    v.e.stall = 1; v.e.idfl = 1; tbl.push_back(v);
    v = '0; v.i.jump = 1; v.e.ififl = 1; tbl.push_back(v);
    v = '0; v.i.br = 1; v.e.ififl = 1; v.e.idfl = 1; tbl.push_back(v);
    v = '0; v.i.ex_memr = 1; v.i.ex_we = 5; v.i.use_rt = 1; v.i.id_rt = 5;
    v.i.br = 1; v.i.is_md = 1; v.e.ififl = 1; v.e.idfl = 1; tbl.push_back(v);
    v = '0; v.i.ex_memr = 1; v.i.ex_we = 5; v.i.use_rs = 1; v.i.id_rs = 5;
    v.i.jump = 1; v.e.stall = 1; v.e.idfl = 1; tbl.push_back(v);
    v = '0; v.i.jump = 1; v.e.ififl = 1; tbl.push_back(v);

    // ---- reset state ----
    i = '0; i.rst = 1; i.mem_rw = 1; i.mem_we = 4; i.ex_rs = 4; i.jump = 1; i.br = 1;
    cyc(i, '0, "rst0");
    cyc(i, '0, "rst1");

    foreach (tbl[k]) cyc(tbl[k].i, tbl[k].e, $sformatf("tbl%0d", k));
    cyc('0, '0, "idle");

    // ---- divide followed by mflo ----
    i = '0; i.is_md = 1; i.md_div = 1; e = '0; e.start = 1;
    cyc(i, e, "div.issue");
    i = '0; i.hilo = 1; e = '0; e.busy = 1; e.stall = 1; e.idfl = 1;
    for (int k = 0; k < 10; k++) cyc(i, e, $sformatf("div.busy%0d", k));
    cyc(i, '0, "div.release");

    // ---- back-to-back mult: second is held by md_hz, then issues ----
    i = '0; i.is_md = 1; e = '0; e.start = 1;
    cyc(i, e, "mul.issue");
    e = '0; e.busy = 1; e.stall = 1; e.idfl = 1;
    for (int k = 0; k < 5; k++) cyc(i, e, $sformatf("mul.hold%0d", k));
    e = '0; e.start = 1;
    cyc(i, e, "mul.reissue");
    e = '0; e.busy = 1;
    cyc('0, e, "mul2.b0");
    i = '0; i.br = 1; e.ififl = 1; e.idfl = 1;
    cyc(i, e, "mul2.branch");
    e = '0; e.busy = 1;
    for (int k = 2; k < 5; k++) cyc('0, e, $sformatf("mul2.b%0d", k));
    cyc('0, '0, "mul2.done");

    // ---- reset in the 3rd BUSY cycle of a divide ----
    i = '0; i.is_md = 1; i.md_div = 1; e = '0; e.start = 1;
    cyc(i, e, "rdiv.issue");
    e = '0; e.busy = 1;
    cyc('0, e, "rdiv.b0");
    cyc('0, e, "rdiv.b1");
    i = '0; i.rst = 1; i.hilo = 1; i.jump = 1; i.mem_rw = 1; i.mem_we = 6;
    i.ex_rs = 6; i.ex_rt = 6;
    cyc(i, '0, "rdiv.reset");
    cyc('0, '0, "rdiv.after");
    i = '0; i.is_md = 1; i.md_div = 1; e = '0; e.start = 1;
    cyc(i, e, "ndiv.issue");
    e = '0; e.busy = 1;
    for (int k = 0; k < 10; k++) cyc('0, e, $sformatf("ndiv.b%0d", k));
    cyc('0, '0, "ndiv.done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined MIPS datapath (IF/ID/EX/MEM/WB).
- Generates EX operand forwarding selects, the load-use stall, and branch/jump flushes.
- Sequences the multi-cycle MULT/DIV unit: start pulse, busy tracking, stall on HI/LO hazards.
- Keeps stall and flush cycle counters for performance inspection.

Parameters:
MD_MUL_CYCLES, 5, cycles the MULT/MULTU operation occupies the MD unit (>=1)
MD_DIV_CYCLES, 10, cycles the DIV/DIVU operation occupies the MD unit (>=MD_MUL_CYCLES)
CNT_W, 32, width of the performance counters

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
ID_Rs  in  5  rs field of the instruction in ID
ID_Rt  in  5  rt field of the instruction in ID
ID_UseRs  in  1  ID instruction reads rs
ID_UseRt  in  1  ID instruction reads rt
ID_IsMd  in  1  ID instruction is mult/multu/div/divu
ID_MdIsDiv  in  1  ID MD instruction is a divide
ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
ID_Jump  in  1  ID instruction is j/jal/jr
EX_Rs  in  5  rs of the instruction in EX
EX_Rt  in  5  rt of the instruction in EX
EX_WeSel  in  5  destination register in EX
EX_MemR  in  1  EX instruction is a load
EX_BranchTaken  in  1  branch resolved taken in EX
MEM_WeSel  in  5  destination register in MEM
MEM_RegW  in  1  MEM instruction writes the GPR
WB_WeSel  in  5  destination register in WB
WB_RegW  in  1  WB instruction writes the GPR
FwdA  out  2  EX operand A select: 00 GPR, 10 MEM result, 01 WB data
FwdB  out  2  EX operand B select, same encoding
PcStall  out  1  hold PC
IfIdStall  out  1  hold the IF/ID register
IfIdFlush  out  1  clear the IF/ID register to a nop
IdExFlush  out  1  insert a bubble into ID/EX
MdStart  out  1  one-cycle start pulse to the MD unit
MdBusy  out  1  MD unit occupied
StallCycles  out  CNT_W  count of cycles with PcStall=1
FlushCycles  out  CNT_W  count of cycles with IfIdFlush=1

Behaviour:
- Reset
  - While Reset=1, every output is 0, including FwdA/FwdB=00.
  - Reset clears the FSM to IDLE, the MD counter to 0, and both performance counters to 0.
  - Reset asserted mid-MD operation aborts tracking; MdBusy=0 the cycle after.
- Forwarding (combinational)
  - FwdA=10 if MEM_RegW, MEM_WeSel!=0, and MEM_WeSel==EX_Rs.
  - Otherwise FwdA=01 if WB_RegW, WB_WeSel!=0, and WB_WeSel==EX_Rs.
  - Otherwise FwdA=00.
  - FwdB uses the same rule with EX_Rt. When both MEM and WB match, MEM wins.
- Load-use stall
  - lu = EX_MemR, EX_WeSel!=0, and either (ID_UseRs and ID_Rs==EX_WeSel) or (ID_UseRt and ID_Rt==EX_WeSel).
  - Register $0 never causes a hazard.
- MD FSM, states IDLE and BUSY, counter cnt of width clog2(MD_DIV_CYCLES)
  - IDLE: issue = ID_IsMd and !lu and !EX_BranchTaken.
  - On issue: MdStart=1 that cycle; cnt loads (ID_MdIsDiv ? MD_DIV_CYCLES : MD_MUL_CYCLES)-1; next state BUSY.
  - BUSY: MdBusy=1.
    - If cnt!=0: cnt decrements.
    - If cnt==0: next state IDLE.
  - md_hz = BUSY and (ID_IsMd or ID_ReadsHiLo). This is asserted in every BUSY cycle, including cnt==0.
  - A stalled MD instruction is issued in the first IDLE cycle.
  - MdStart is never asserted in BUSY. MdStart is never asserted in two consecutive cycles.
- Stall/flush combine
  - stall = (lu or md_hz) and !EX_BranchTaken.
  - PcStall = IfIdStall = stall.
  - IfIdFlush = EX_BranchTaken or (ID_Jump and !stall).
  - IdExFlush = stall or EX_BranchTaken.
- Precedence
  - A taken branch overrides any stall: the ID instruction is wrong-path and is squashed.
  - A branch does not abort an MD operation already in BUSY.
- Counters
  - StallCycles increments on each cycle with PcStall=1; FlushCycles on each cycle with IfIdFlush=1.
  - Both wrap modulo 2^CNT_W.

Decomposition:
- Shared package pipe_pkg holds the FWD_GPR/FWD_WB/FWD_MEM encodings (00/01/10), the MD FSM state encoding, and REG_W=5.
- One sub-module, md_seq: the MD FSM plus cnt, with outputs MdStart, MdBusy and md_hz.
- Forwarding, load-use detection, combine logic and counters stay in hazard_ctrl.

Test Plan:
- MEM_RegW=1, MEM_WeSel=8, WB_RegW=1, WB_WeSel=8, EX_Rs=8, EX_Rt=9 -> FwdA=10, FwdB=00. With WB_WeSel=9 instead -> FwdB=01. Repeat with all regs =0 -> FwdA=FwdB=00.
- EX_MemR=1, EX_WeSel=5, ID_UseRt=1, ID_Rt=5 -> PcStall=IfIdStall=IdExFlush=1 for 1 cycle, StallCycles 0->1. Same with ID_UseRt=0 -> no stall.
- ID_IsMd=1, ID_MdIsDiv=1 in IDLE -> MdStart=1 for 1 cycle, then MdBusy=1 for exactly 10 cycles. A following mflo (ID_ReadsHiLo=1) stalls all 10 BUSY cycles and releases on cycle 11. Mult -> 5 cycles.
- Load-use hazard with EX_BranchTaken=1 in the same cycle -> stall=0, IfIdFlush=IdExFlush=1, FlushCycles +1, no MdStart even if ID_IsMd=1.
- ID_Jump=1 while lu=1 -> IfIdFlush=0 that cycle, stall=1. The next cycle with lu=0 -> IfIdFlush=1.
- Reset=1 asserted in the 3rd BUSY cycle of a divide -> all outputs 0 during reset. After release: MdBusy=0, StallCycles=FlushCycles=0, and a new MD issue starts a fresh count.
